// File: rtl/ltl_report_collector.sv
// ============================================================================
// Module   : ltl_report_collector
// Purpose  : Timestamps masked LTL report vectors and buffers them in a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 32,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic                            clear,
  input  logic [NUM_REPORTS-1:0]          report_mask,
  input  logic [NUM_REPORTS-1:0]          report_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TS_WIDTH+NUM_REPORTS-1:0] out_data,
  output logic                            violation,
  output logic [DROP_WIDTH-1:0]           drop_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = TS_WIDTH + NUM_REPORTS;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  logic [REC_W-1:0]       mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   violation_q, violation_d;
  logic [DROP_WIDTH-1:0]  drop_q, drop_d;

  logic [NUM_REPORTS-1:0] w_masked;
  logic                   w_push_req;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push_en;
  logic                   w_drop;

  assign w_masked   = report_in & report_mask;
  assign w_push_req = run && (w_masked != '0);
  assign w_full     = (level_q == DEPTH_LVL);
  assign w_pop      = (level_q != '0) && out_ready && !clear;
  // A simultaneous pop frees the slot this edge, so a full FIFO still accepts.
  assign w_push_en  = w_push_req && !clear && (!w_full || w_pop);
  assign w_drop     = w_push_req && !clear && w_full && !w_pop;

  always_comb begin
    ts_d        = ts_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    violation_d = violation_q;
    drop_d      = drop_q;
    if (clear) begin
      ts_d        = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      violation_d = 1'b0;
      drop_d      = '0;
    end else begin
      if (run) begin
        ts_d = ts_q + TS_WIDTH'(1);
      end
      if (w_push_req) begin
        violation_d = 1'b1;
      end
      if (w_push_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (w_push_en && !w_pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (!w_push_en && w_pop) begin
        level_d = level_q - LVL_W'(1);
      end
      if (w_drop && (drop_q != {DROP_WIDTH{1'b1}})) begin
        drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      violation_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      violation_q <= violation_d;
      drop_q      <= drop_d;
    end
  end

  // Storage needs no reset: contents are only observable while level is non-zero.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      mem_q[wr_ptr_q] <= {ts_q, w_masked};
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign violation  = violation_q;
  assign drop_count = drop_q;
  assign fifo_level = level_q;

endmodule

`default_nettype wire

// File: tb/tb_ltl_report_collector.sv
// ============================================================================
// Module   : tb_ltl_report_collector
// Purpose  : Scoreboard bench for ltl_report_collector (plus a TS_WIDTH=4 copy).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ltl_report_collector;

  localparam int NR    = 4;
  localparam int DEPTH = 8;
  localparam int TSW   = 32;
  localparam int DW    = 8;
  localparam int RW    = TSW + NR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic [NR-1:0] report_mask = 4'hF;
  logic [NR-1:0] report_in = 4'h0;

  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          violation;
  logic [DW-1:0] drop_count;
  logic [3:0]    fifo_level;

  logic          u4_valid;
  logic [7:0]    u4_data;
  logic          u4_viol;
  logic [DW-1:0] u4_drop;
  logic [3:0]    u4_level;

  ltl_report_collector #(.NUM_REPORTS(NR), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW), .DROP_WIDTH(DW)) u_dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .report_mask(report_mask), .report_in(report_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .violation(violation), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  ltl_report_collector #(.NUM_REPORTS(NR), .FIFO_DEPTH(DEPTH), .TS_WIDTH(4), .DROP_WIDTH(DW)) u_dut4 (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .report_mask(report_mask), .report_in(report_in),
    .out_valid(u4_valid), .out_ready(out_ready), .out_data(u4_data),
    .violation(u4_viol), .drop_count(u4_drop), .fifo_level(u4_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [RW-1:0]  exp_q[$];
  logic [TSW-1:0] m_ts = '0;
  int             m_level = 0;
  int             m_drop = 0;
  bit             m_viol = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the head must match the oldest expected record whenever valid.
  always @(negedge clk) begin
    if (!reset && !clear && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no record", out_data);
      end else begin
        chk("sb_data", 64'(out_data), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    logic [NR-1:0] m;
    bit preq, pop, full;
    m    = report_in & report_mask;
    preq = run && (m != 0);
    if (clear) begin
      exp_q.delete();
      m_ts = '0; m_level = 0; m_drop = 0; m_viol = 1'b0;
    end else begin
      pop  = (m_level != 0) && out_ready;
      full = (m_level == DEPTH);
      if (preq) begin
        m_viol = 1'b1;
        if (!full || pop) begin
          exp_q.push_back({m_ts, m});
          m_level++;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (pop) m_level--;
      if (run) m_ts++;
    end
    @(posedge clk);
    #1;
    chk("level", 64'(fifo_level), 64'(m_level));
    chk("valid", 64'(out_valid), 64'(m_level != 0));
    chk("drop", 64'(drop_count), 64'(m_drop));
    chk("violation", 64'(violation), 64'(m_viol));
  endtask

  task automatic run_cyc(input bit r, input logic [NR-1:0] rep);
    run = r;
    report_in = rep;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lfsr;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_viol", 64'(violation), 64'd0);

    // Basic capture: one report on the third run cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cyc(1'b1, (i == 2) ? 4'b0100 : 4'b0000);
      if (i == 2) begin
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_data", 64'(out_data), 64'({32'd2, 4'b0100}));
      end
    end
    chk("basic_level", 64'(fifo_level), 64'd1);
    chk("basic_viol", 64'(violation), 64'd1);
    out_ready = 1'b1;
    repeat (2) run_cyc(1'b0, 4'b0000);

    // Masking and run gating.
    do_clear();
    report_mask = 4'b1011;
    repeat (10) run_cyc(1'b1, 4'b0100);
    chk("mask_viol", 64'(violation), 64'd0);
    chk("mask_level", 64'(fifo_level), 64'd0);
    repeat (3) run_cyc(1'b0, 4'b0101);
    chk("gate_level", 64'(fifo_level), 64'd0);
    chk("gate_viol", 64'(violation), 64'd0);
    out_ready = 1'b0;
    run_cyc(1'b1, 4'b0101);
    chk("gate_ts", 64'(out_data), 64'({32'd10, 4'b0001}));
    out_ready = 1'b1;
    run_cyc(1'b0, 4'b0000);

    // Overflow, then full with simultaneous push and pop.
    do_clear();
    report_mask = 4'hF;
    out_ready = 1'b0;
    repeat (12) run_cyc(1'b1, 4'b0001);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_drop", 64'(drop_count), 64'd4);
    chk("ovf_head", 64'(out_data), 64'({32'd0, 4'b0001}));
    out_ready = 1'b1;
    run_cyc(1'b1, 4'b0010);
    chk("fullpp_level", 64'(fifo_level), 64'd8);
    chk("fullpp_drop", 64'(drop_count), 64'd4);
    chk("fullpp_head", 64'(out_data), 64'({32'd1, 4'b0001}));
    repeat (10) run_cyc(1'b0, 4'b0000);
    chk("ovf_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: 50 pushes with pseudo-random ready.
    do_clear();
    lfsr = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      out_ready = lfsr[0] | lfsr[1];
      run_cyc(i % 2 == 0, 4'b1000);
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    out_ready = 1'b1;
    repeat (10) run_cyc(1'b0, 4'b0000);
    chk("bp_drop", 64'(drop_count), 64'd0);
    chk("bp_delivered", 64'(exp_q.size()), 64'd0);

    // Timestamp wrap on the 4-bit instance.
    do_clear();
    repeat (16) run_cyc(1'b1, 4'b0000);
    out_ready = 1'b0;
    run_cyc(1'b1, 4'b0001);
    chk("wrap_data4", 64'(u4_data), 64'h01);
    chk("wrap_valid4", 64'(u4_valid), 64'd1);
    chk("wrap_level4", 64'(u4_level), 64'd1);
    chk("wrap_drop4", 64'(u4_drop), 64'd0);
    chk("wrap_viol4", 64'(u4_viol), 64'd1);
    chk("wrap_data32", 64'(out_data), 64'({32'd16, 4'b0001}));
    out_ready = 1'b1;
    repeat (2) run_cyc(1'b0, 4'b0000);

    // Clear with a report active on the same edge.
    out_ready = 1'b0;
    repeat (3) run_cyc(1'b1, 4'b0011);
    run = 1'b1;
    report_in = 4'b0011;
    do_clear();
    chk("clr_level", 64'(fifo_level), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_viol", 64'(violation), 64'd0);
    chk("clr_drop", 64'(drop_count), 64'd0);
    run_cyc(1'b1, 4'b0100);
    chk("clr_ts0", 64'(out_data), 64'({32'd0, 4'b0100}));

    // Asynchronous reset in the middle of a drain.
    repeat (3) run_cyc(1'b1, 4'b0001);
    out_ready = 1'b1;
    run_cyc(1'b0, 4'b0000);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_viol", 64'(violation), 64'd0);
    exp_q.delete();
    m_ts = '0; m_level = 0; m_drop = 0; m_viol = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b0;
    run_cyc(1'b1, 4'b0010);
    chk("arst_ts0", 64'(out_data), 64'({32'd0, 4'b0010}));
    out_ready = 1'b1;
    repeat (2) run_cyc(1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Downstream of an LTL automata cluster; consumes the cluster's one-bit report outputs, one per report STE.
- Each run cycle with at least one unmasked report active produces a timestamped event record.
- Records are buffered in a FIFO and drained over a valid/ready interface toward the monitor's trace/interrupt logic.
- Also keeps a sticky violation flag and a saturating drop counter for lost records.

Parameters:
- NUM_REPORTS, 4, number of report inputs (bit i = i-th report output of the cluster, in port order).
- FIFO_DEPTH, 8, record FIFO entries; power of two, >= 2.
- TS_WIDTH, 32, width of symbol timestamp counter.
- DROP_WIDTH, 8, width of dropped-record counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  symbol-valid strobe, same signal that drives the automata cluster.
- clear  in  1  synchronous clear of FIFO, timestamp, drop counter and sticky flag.
- report_mask  in  NUM_REPORTS  1 = report bit enabled.
- report_in  in  NUM_REPORTS  active_state outputs of the cluster's report STEs.
- out_valid  out  1  FIFO head holds a record.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  TS_WIDTH+NUM_REPORTS  {timestamp, masked report vector}; report vector in the LSBs.
- violation  out  1  sticky: any enabled report seen since reset/clear.
- drop_count  out  DROP_WIDTH  records lost to FIFO full; saturates at all-ones.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, out_data=0, timestamp=0, violation=0, drop_count=0, fifo_level=0.
- Timestamp counter:
  - increments by 1 at each clk edge with run=1;
  - wraps modulo 2^TS_WIDTH with no flag;
  - holds when run=0.
- Masked vector m = report_in & report_mask, sampled at the clk edge.
- Push request: run=1 and m != 0.
  - Pushed record = {timestamp value before this edge's increment, m}.
  - With run=0, reports are ignored entirely: no push, no violation update.
- violation: set at the edge where a push request occurs, regardless of FIFO space; stays set until reset or clear.
- Pop occurs at an edge with out_valid=1 and out_ready=1.
- out_valid and out_data:
  - out_valid = (fifo_level != 0); out_data = head entry, both driven from registers/RAM head (first-word fall-through).
  - A record pushed at edge k is visible on out_valid/out_data after edge k, so out_valid rises one cycle after the push request.
  - out_data is stable while out_valid=1 and out_ready=0.
- Full handling:
  - Push with fifo_level=FIFO_DEPTH and no pop in the same edge: record dropped; drop_count += 1, saturating.
  - Push with FIFO full and a simultaneous pop: both performed; no drop; level unchanged.
  - Push and pop on a non-full, non-empty FIFO: level unchanged.
- Empty: out_ready ignored when out_valid=0; no underflow.
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrapping naturally; level tracked explicitly.
- clear:
  - Has priority over push/pop in the same edge; the report on that edge is discarded.
  - Resets timestamp, FIFO, violation and drop_count to their reset values.
  - report_mask is unaffected.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values; partially drained records are lost.
- No combinational path from report_in or run to any output; out_ready reaches outputs only through registered state.

Test Plan:
- Basic capture: reset, run=1 for 5 cycles, report_in=4'b0100 on the 3rd run cycle only -> exactly one record; out_data={32'd2,4'b0100} visible the cycle after; violation=1; fifo_level=1.
- Masking and gating: report_mask=4'b1011, report_in=4'b0100 for 10 run cycles -> no records, violation=0; then report_in=4'b0101 with run=0 -> no record, timestamp unchanged.
- Overflow: out_ready=0, reports on 12 consecutive run cycles, FIFO_DEPTH=8 -> fifo_level=8, drop_count=4; drained records carry timestamps 0..7 in order.
- Full with simultaneous push/pop: FIFO full, out_ready=1 and push on the same edge -> drop_count unchanged, level stays 8, head advances by one.
- Backpressure/stability: out_ready toggled 1/0 pseudo-randomly over 50 pushes -> out_data unchanged whenever out_valid=1 and out_ready=0; all 50 records delivered in order.
- Clear, wrap and reset: preload timestamp near 2^32-1 via long run (or TS_WIDTH=4 variant: 17 run cycles -> a report timestamps as 0); clear asserted with a report active -> no record, all counters 0; async reset asserted mid-drain -> out_valid=0 before the next clk edge.
